md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL have a parameter MULT_CYCLES, default 5, meaning the number of Busy cycles for mult/multu.
REQ-002 The block SHALL have a parameter DIV_CYCLES, default 10, meaning the number of Busy cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port MDop, input, 3 bits: E-stage operation code; 000 none, 001 mthi, 010 mtlo, 011 mult, 100 multu, 101 div, 110 divu, 111 none.
REQ-006 The block SHALL have port A, input, 32 bits: E-stage rs operand (dividend, multiplicand, or mthi/mtlo source).
REQ-007 The block SHALL have port B, input, 32 bits: E-stage rt operand (divisor or multiplier).
REQ-008 The block SHALL have port mdUse_D, input, 1 bit: the D-stage instruction is mfhi, mflo, mthi, mtlo, mult, multu, div or divu.
REQ-009 The block SHALL have port Start, output, 1 bit: combinational; MDop is 011..110.
REQ-010 The block SHALL have port Busy, output, 1 bit, registered: a mult/div is in progress.
REQ-011 The block SHALL have port HI, output, 32 bits, registered: architectural HI.
REQ-012 The block SHALL have port LO, output, 32 bits, registered: architectural LO.
REQ-013 The block SHALL have port Stall_md, output, 1 bit: combinational; equals mdUse_D && (Start || Busy).

Function
REQ-014 On a rising edge with MDop in 011..110 and Busy=0, the block SHALL latch the result of A op B into internal pending registers, load an internal counter with MULT_CYCLES or DIV_CYCLES, and set Busy=1.
REQ-015 While the counter is nonzero, it SHALL decrement by one each edge; on the 1->0 edge the block SHALL copy the pending registers into HI/LO and clear Busy, so Busy is high for exactly N cycles after the issue edge.
REQ-016 The block SHALL NOT change HI/LO during Busy, and mfhi/mflo SHALL be able to read the new values in the cycle after Busy falls.
REQ-017 mult/multu SHALL produce a signed/unsigned 64-bit product, with HI=[63:32] and LO=[31:0].
REQ-018 div/divu SHALL produce a signed/unsigned quotient in LO and remainder in HI, truncating toward zero, with the remainder taking the sign of the dividend.
REQ-019 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-020 When Busy=0, mthi SHALL load HI<=A and mtlo SHALL load LO<=A at the next edge, with no Busy.
REQ-021 When Busy=1, any MDop (including mthi/mtlo or a new mult/div) SHALL be ignored; the bench guarantees this via Stall_md, but the block SHALL tolerate it.
REQ-022 MDop=000 or 111 SHALL have no effect.
REQ-023 An issue in the same cycle that Busy falls SHALL be ignored, because Busy is still 1 at that edge.
REQ-024 Stall_md SHALL be asserted in the issue cycle (via Start) and in every Busy cycle whenever mdUse_D=1.

Reset
REQ-025 On reset=1, regardless of clk, the block SHALL set HI=0, LO=0, Busy=0, counter=0 and pending=0 immediately.
REQ-026 Reset mid-operation SHALL discard the pending result, and HI/LO SHALL remain 0 after reset releases.
REQ-027 Start and Stall_md SHALL follow their inputs during reset, while Busy=0 holds.

Configuration
REQ-028 The macro MD_DIV0_KEEP_EN SHALL control divide-by-zero behaviour.
REQ-029 With MD_DIV0_KEEP_EN defined, div/divu with B=0 SHALL still be Busy for DIV_CYCLES but SHALL leave HI/LO unchanged.
REQ-030 With MD_DIV0_KEEP_EN undefined, div/divu with B=0 SHALL write HI=A and LO=32'hFFFFFFFF after DIV_CYCLES.

Verification
REQ-031 Bench SHALL cover: mult A=32'hFFFFFFFE(-2), B=3 -> Busy high 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-032 Bench SHALL cover: multu A=32'hFFFFFFFF, B=2 -> after 5 cycles, HI=1 and LO=32'hFFFFFFFE.
REQ-033 Bench SHALL cover: div A=-7, B=2 -> Busy 10 cycles; LO=32'hFFFFFFFD and HI=32'hFFFFFFFF; with mdUse_D=1 throughout, Stall_md is high in the issue cycle plus 10 cycles, then low.
REQ-034 Bench SHALL cover: mthi A=32'h12345678 while idle -> HI=32'h12345678 next cycle with Busy=0; the same mthi during Busy -> HI unchanged.
REQ-035 Bench SHALL cover: divu A=9, B=0 -> with the macro, HI/LO unchanged; without the macro, HI=9 and LO=32'hFFFFFFFF.
REQ-036 Bench SHALL cover: reset pulse in the 3rd Busy cycle of mult 6x7 -> Busy=0 and HI=LO=0 immediately; LO never becomes 42.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer that owns architectural HI/LO,
// holds Busy for a fixed number of cycles per operation and raises a
// D-stage stall while a HI/LO consumer would race the unit.
// Optional build macro: MD_DIV0_KEEP_EN -- when defined, a divide by zero
// still occupies the unit for DIV_CYCLES but leaves HI/LO untouched;
// otherwise it writes HI=A and LO=32'hFFFFFFFF.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mdUse_D,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Stall_md
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MTHI  = 3'b001,
    OP_MTLO  = 3'b010,
    OP_MULT  = 3'b011,
    OP_MULTU = 3'b100,
    OP_DIV   = 3'b101,
    OP_DIVU  = 3'b110,
    OP_NONE7 = 3'b111
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Result of an issued operation packed as {write_enable, hi, lo}.
  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0 without relying on overflow semantics.
  function automatic logic [64:0] md_result(input md_op_e op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [64:0] res;
    prod  = 64'd0;
    mag_a = 32'd0;
    mag_b = 32'd0;
    quo   = 32'd0;
    rem   = 32'd0;
    res   = 65'd0;
    case (op)
      OP_MULT: begin
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res  = {1'b1, prod};
      end
      OP_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        res  = {1'b1, prod};
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
          res = {1'b0, 64'd0};
`else
          res = {1'b1, a, 32'hFFFF_FFFF};
`endif
        end else if (op == OP_DIV) begin
          mag_a = a[31] ? (32'd0 - a) : a;
          mag_b = b[31] ? (32'd0 - b) : b;
          quo   = mag_a / mag_b;
          rem   = mag_a % mag_b;
          quo   = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
          rem   = a[31] ? (32'd0 - rem) : rem;
          res   = {1'b1, rem, quo};
        end else begin
          res = {1'b1, a % b, a / b};
        end
      end
      default: begin
        res = 65'd0;
      end
    endcase
    return res;
  endfunction

  state_e             state_r;
  state_e             state_nx;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nx;
  logic [31:0]        pend_hi_r;
  logic [31:0]        pend_hi_nx;
  logic [31:0]        pend_lo_r;
  logic [31:0]        pend_lo_nx;
  logic               pend_wr_r;
  logic               pend_wr_nx;
  logic [31:0]        hi_r;
  logic [31:0]        hi_nx;
  logic [31:0]        lo_r;
  logic [31:0]        lo_nx;
  md_op_e             op_s;
  logic               start_s;
  logic [64:0]        res_s;

  assign op_s    = md_op_e'(MDop);
  assign start_s = (MDop >= 3'b011) && (MDop <= 3'b110);
  assign res_s   = md_result(op_s, A, B);

  assign Start    = start_s;
  assign Busy     = (state_r == ST_BUSY);
  assign HI       = hi_r;
  assign LO       = lo_r;
  assign Stall_md = mdUse_D && (start_s || (state_r == ST_BUSY));

  // Next-state, counter, pending result and HI/LO update decisions.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    pend_hi_nx = pend_hi_r;
    pend_lo_nx = pend_lo_r;
    pend_wr_nx = pend_wr_r;
    hi_nx      = hi_r;
    lo_nx      = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nx   = ST_BUSY;
          pend_wr_nx = res_s[64];
          pend_hi_nx = res_s[63:32];
          pend_lo_nx = res_s[31:0];
          if ((op_s == OP_MULT) || (op_s == OP_MULTU)) begin
            cnt_nx = CNT_W'(MULT_CYCLES);
          end else begin
            cnt_nx = CNT_W'(DIV_CYCLES);
          end
        end else if (op_s == OP_MTHI) begin
          hi_nx = A;
        end else if (op_s == OP_MTLO) begin
          lo_nx = A;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Any MDop arriving while busy is dropped, including one that
        // lands on the edge where Busy falls.
        if (cnt_r <= CNT_W'(1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = {CNT_W{1'b0}};
          if (pend_wr_r) begin
            hi_nx = pend_hi_r;
            lo_nx = pend_lo_r;
          end else begin
            hi_nx = hi_r;
            lo_nx = lo_r;
          end
        end else begin
          cnt_nx = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      pend_hi_r <= pend_hi_nx;
      pend_lo_r <= pend_lo_nx;
      pend_wr_r <= pend_wr_nx;
      hi_r      <= hi_nx;
      lo_r      <= lo_nx;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed and randomized checks of md_sequencer against
// a cycle-count reference model using 64-bit integer arithmetic.
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  MDop;
  logic [31:0] A;
  logic [31:0] B;
  logic        mdUse_D;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Stall_md;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_busy;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] m_phi;
  logic [31:0] m_plo;
  bit          m_wr;
  int          busy_seen;
  int          stall_seen;
  logic [31:0] save_hi;
  logic [31:0] save_lo;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .MDop     (MDop),
    .A        (A),
    .B        (B),
    .mdUse_D  (mdUse_D),
    .Start    (Start),
    .Busy     (Busy),
    .HI       (HI),
    .LO       (LO),
    .Stall_md (Stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_phi  = 32'd0;
    m_plo  = 32'd0;
    m_wr   = 1'b0;
  endtask

  // Compute what an issued operation will eventually write to HI/LO.
  task automatic model_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    logic [63:0] q64;
    logic [63:0] r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_wr = 1'b1;
    if (op == 3'd3) begin
      p = sa * sb;
      m_phi = p[63:32];
      m_plo = p[31:0];
    end else if (op == 3'd4) begin
      p = {32'd0, a} * {32'd0, b};
      m_phi = p[63:32];
      m_plo = p[31:0];
    end else if (b == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
      m_wr = 1'b0;
`else
      m_phi = a;
      m_plo = 32'hFFFF_FFFF;
`endif
    end else if (op == 3'd5) begin
      q = sa / sb;
      r = sa % sb;
      q64 = q;
      r64 = r;
      m_plo = q64[31:0];
      m_phi = r64[31:0];
    end else begin
      m_plo = a / b;
      m_phi = a % b;
    end
  endtask

  task automatic model_edge(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (op >= 3'd3 && op <= 3'd6) begin
      model_issue(op, a, b);
      m_busy = (op <= 3'd4) ? MULT_N : DIV_N;
    end else if (op == 3'd1) begin
      m_hi = a;
    end else if (op == 3'd2) begin
      m_lo = a;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, edge, check registers.
  task automatic cycle(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
    bit st;
    MDop    = op;
    A       = a;
    B       = b;
    mdUse_D = use_d;
    #1;
    st = (op >= 3'd3 && op <= 3'd6);
    chk("start", Start, st);
    chk("stall", Stall_md, use_d && (st || m_busy > 0));
    if (Stall_md) stall_seen++;
    @(posedge clk);
    model_edge(op, a, b);
    #1;
    chk("busy", Busy, m_busy > 0);
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
    if (Busy) busy_seen++;
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int i = 0; i < n; i++) cycle(3'd0, 32'd0, 32'd0, use_d);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_start", Start, (MDop >= 3'd3 && MDop <= 3'd6));
    chk("rst_stall", Stall_md, mdUse_D && (MDop >= 3'd3 && MDop <= 3'd6));
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    reset   = 1'b1;
    MDop    = 3'd0;
    A       = 32'd0;
    B       = 32'd0;
    mdUse_D = 1'b0;
    model_reset();
    #2;
    chk("reset_busy", Busy, 1'b0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mult -2 * 3
    busy_seen = 0;
    cycle(3'd3, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(6, 1'b0);
    chk("mult_busy_len", busy_seen, 5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFF * 2
    busy_seen = 0;
    cycle(3'd4, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(6, 1'b0);
    chk("multu_busy_len", busy_seen, 5);
    chk("multu_hi", HI, 32'd1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // div -7 / 2 with a consumer waiting in D
    busy_seen  = 0;
    stall_seen = 0;
    cycle(3'd5, 32'hFFFF_FFF9, 32'd2, 1'b1);
    idle(12, 1'b1);
    chk("div_busy_len", busy_seen, 10);
    chk("div_stall_len", stall_seen, 11);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // mthi while idle, then mthi while busy
    cycle(3'd1, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_busy", Busy, 1'b0);
    cycle(3'd3, 32'd2, 32'd3, 1'b0);
    cycle(3'd1, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("mthi_ignored", HI, 32'h1234_5678);
    idle(5, 1'b0);
    chk("mult23_lo", LO, 32'd6);

    // divu by zero
    save_hi = HI;
    save_lo = LO;
    busy_seen = 0;
    cycle(3'd6, 32'd9, 32'd0, 1'b0);
    idle(11, 1'b0);
    chk("div0_busy_len", busy_seen, 10);
`ifdef MD_DIV0_KEEP_EN
    chk("div0_hi", HI, save_hi);
    chk("div0_lo", LO, save_lo);
`else
    chk("div0_hi", HI, 32'd9);
    chk("div0_lo", LO, 32'hFFFF_FFFF);
`endif

    // issue on the edge where Busy falls is dropped
    cycle(3'd3, 32'd5, 32'd5, 1'b0);
    idle(4, 1'b0);
    cycle(3'd3, 32'd7, 32'd7, 1'b0);
    chk("fall_issue_busy", Busy, 1'b0);
    chk("fall_issue_lo", LO, 32'd25);

    // signed overflow divide
    cycle(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(10, 1'b0);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);

    // reset in third Busy cycle of 6 * 7
    cycle(3'd3, 32'd6, 32'd7, 1'b0);
    idle(2, 1'b0);
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(3'd0, 32'd0, 32'd0, 1'b0);
      chk("no_42", LO == 32'd42, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      cycle(op, ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 149) == 0) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
